// File: rtl/vegeta_pkg.sv
// Shared definitions for the VEGETA weight packer: block geometry,
// packer FSM states and the sparsity-degree decode.
package vegeta_pkg;

  localparam int BLOCK_SIZE     = 4;
  localparam int META_DATA_SIZE = 2;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    FLUSH,
    DONE
  } packer_state_t;

  // Any degree other than 1 or 2 selects the dense 4:4 layout.
  function automatic logic [2:0] sparsity_to_n(input logic [31:0] degree);
    case (degree)
      32'd1:   sparsity_to_n = 3'd1;
      32'd2:   sparsity_to_n = 3'd2;
      default: sparsity_to_n = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/vegeta_block_compress.sv
// Combinational N:4 selector for one dense block. Picks the first N
// nonzero elements, pads with the lowest unused zero positions, and
// presents the kept values/indices in ascending index order.
module vegeta_block_compress
  import vegeta_pkg::*;
#(
  parameter int MUL_DATAWIDTH = 16
) (
  input  logic [BLOCK_SIZE*MUL_DATAWIDTH-1:0]        blk_data,
  input  logic [2:0]                                 n,
  output logic [BLOCK_SIZE-1:0][MUL_DATAWIDTH-1:0]   values,
  output logic [BLOCK_SIZE-1:0][META_DATA_SIZE-1:0]  indices,
  output logic                                       violation
);

  logic [BLOCK_SIZE-1:0] nonzero;
  logic [BLOCK_SIZE-1:0] selected;
  logic [2:0]            nz_count;
  logic [2:0]            taken;
  logic [1:0]            slot;

  // Build the selection mask, then compact the selected elements in index order.
  always_comb begin
    nonzero  = '0;
    selected = '0;
    nz_count = '0;
    taken    = '0;
    slot     = '0;
    values   = '0;
    indices  = '0;

    for (int i = 0; i < BLOCK_SIZE; i++) begin
      nonzero[i] = (blk_data[i*MUL_DATAWIDTH +: MUL_DATAWIDTH] != '0);
      if (nonzero[i]) nz_count = nz_count + 3'd1;
    end

    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (nonzero[i] && (taken < n)) begin
        selected[i] = 1'b1;
        taken       = taken + 3'd1;
      end
    end

    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (!selected[i] && (taken < n)) begin
        selected[i] = 1'b1;
        taken       = taken + 3'd1;
      end
    end

    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (selected[i]) begin
        values[slot]  = blk_data[i*MUL_DATAWIDTH +: MUL_DATAWIDTH];
        indices[slot] = META_DATA_SIZE'(i);
        slot          = slot + 2'd1;
      end
    end

    violation = (nz_count > n);
  end

endmodule

// File: rtl/vegeta_weight_packer.sv
// Packs dense 4-element weight blocks into N:4 structured-sparse form and
// writes kept values to the weight BRAM and 2-bit positions to the
// metadata BRAM, in the layout weight_control reads back.
// Optional: define VEGETA_PACKER_STATS_EN to add per-job statistics ports.
module vegeta_weight_packer
  import vegeta_pkg::*;
#(
  parameter int MUL_DATAWIDTH = 16,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [31:0]                          sparsity_degree,
  input  logic [ADDR_WIDTH-1:0]                weight_base,
  input  logic [ADDR_WIDTH-1:0]                metadata_base,
  input  logic                                 blk_valid,
  output logic                                 blk_ready,
  input  logic [BLOCK_SIZE*MUL_DATAWIDTH-1:0]  blk_data,
  input  logic                                 blk_last,
  output logic [ADDR_WIDTH-1:0]                weight_address,
  output logic [2*MUL_DATAWIDTH-1:0]           weight_data,
  output logic                                 weight_enable,
  output logic [3:0]                           weight_write,
  output logic [ADDR_WIDTH-1:0]                metadata_address,
  output logic [31:0]                          metadata_data,
  output logic                                 metadata_enable,
  output logic [3:0]                           metadata_write,
  output logic                                 pattern_error,
`ifdef VEGETA_PACKER_STATS_EN
  output logic [31:0]                          blk_count,
  output logic [31:0]                          viol_count,
  output logic [31:0]                          weight_words,
`endif
  output logic                                 done
);

  localparam int META_PER_WORD = 32 / META_DATA_SIZE;

  packer_state_t state, state_next;

  logic [2:0]                                n_reg;
  logic [ADDR_WIDTH-1:0]                     weight_ptr;
  logic [ADDR_WIDTH-1:0]                     meta_ptr;
  logic                                      stage_valid;
  logic [2*MUL_DATAWIDTH-1:0]                stage_word;
  logic                                      half_valid;
  logic [MUL_DATAWIDTH-1:0]                  half_value;
  logic [31:0]                               meta_acc;
  logic [4:0]                                meta_count;
  logic [31:0]                               meta_merged;
  logic [4:0]                                meta_count_next;
  logic                                      last_seen;
  logic                                      accept;

  logic [BLOCK_SIZE-1:0][MUL_DATAWIDTH-1:0]  cmp_values;
  logic [BLOCK_SIZE-1:0][META_DATA_SIZE-1:0] cmp_indices;
  logic                                      cmp_violation;

  vegeta_block_compress #(
    .MUL_DATAWIDTH(MUL_DATAWIDTH)
  ) u_compress (
    .blk_data  (blk_data),
    .n         (n_reg),
    .values    (cmp_values),
    .indices   (cmp_indices),
    .violation (cmp_violation)
  );

  assign accept = blk_valid && blk_ready;

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus the handshake/done outputs decoded from state.
  always_comb begin
    state_next = state;
    blk_ready  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = PACK;
      end
      PACK: begin
        blk_ready = !stage_valid && !last_seen;
        if (last_seen && !stage_valid) state_next = FLUSH;
      end
      FLUSH: begin
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Merge the incoming block's indices into the open metadata word.
  always_comb begin
    int pos;
    pos         = 0;
    meta_merged = meta_acc;
    for (int j = 0; j < BLOCK_SIZE; j++) begin
      if (3'(j) < n_reg) begin
        pos = int'(meta_count) + j;
        if (pos < META_PER_WORD)
          meta_merged[pos*META_DATA_SIZE +: META_DATA_SIZE] = cmp_indices[j];
      end
    end
    meta_count_next = meta_count + 5'(n_reg);
  end

  // Staging, half-word/metadata packing, pointers and registered BRAM ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg            <= '0;
      weight_ptr       <= '0;
      meta_ptr         <= '0;
      stage_valid      <= 1'b0;
      stage_word       <= '0;
      half_valid       <= 1'b0;
      half_value       <= '0;
      meta_acc         <= '0;
      meta_count       <= '0;
      last_seen        <= 1'b0;
      pattern_error    <= 1'b0;
      weight_address   <= '0;
      weight_data      <= '0;
      weight_enable    <= 1'b0;
      weight_write     <= 4'h0;
      metadata_address <= '0;
      metadata_data    <= '0;
      metadata_enable  <= 1'b0;
      metadata_write   <= 4'h0;
    end else begin
      weight_enable   <= 1'b0;
      weight_write    <= 4'h0;
      metadata_enable <= 1'b0;
      metadata_write  <= 4'h0;

      case (state)
        IDLE: begin
          if (start) begin
            n_reg         <= sparsity_to_n(sparsity_degree);
            weight_ptr    <= weight_base;
            meta_ptr      <= metadata_base;
            pattern_error <= 1'b0;
            stage_valid   <= 1'b0;
            half_valid    <= 1'b0;
            meta_acc      <= '0;
            meta_count    <= '0;
            last_seen     <= 1'b0;
          end
        end

        PACK: begin
          if (stage_valid) begin
            weight_address <= weight_ptr;
            weight_data    <= stage_word;
            weight_enable  <= 1'b1;
            weight_write   <= 4'hF;
            weight_ptr     <= weight_ptr + 1'b1;
            stage_valid    <= 1'b0;
          end else if (last_seen) begin
            if (half_valid) begin
              weight_address <= weight_ptr;
              weight_data    <= {{MUL_DATAWIDTH{1'b0}}, half_value};
              weight_enable  <= 1'b1;
              weight_write   <= 4'hF;
              weight_ptr     <= weight_ptr + 1'b1;
              half_valid     <= 1'b0;
            end
            if (meta_count != 5'd0) begin
              metadata_address <= meta_ptr;
              metadata_data    <= meta_acc;
              metadata_enable  <= 1'b1;
              metadata_write   <= 4'hF;
              meta_ptr         <= meta_ptr + 1'b1;
              meta_acc         <= '0;
              meta_count       <= '0;
            end
          end else if (accept) begin
            if (cmp_violation) pattern_error <= 1'b1;
            if (blk_last)      last_seen     <= 1'b1;

            case (n_reg)
              3'd1: begin
                if (half_valid) begin
                  weight_address <= weight_ptr;
                  weight_data    <= {cmp_values[0], half_value};
                  weight_enable  <= 1'b1;
                  weight_write   <= 4'hF;
                  weight_ptr     <= weight_ptr + 1'b1;
                  half_valid     <= 1'b0;
                end else begin
                  half_value <= cmp_values[0];
                  half_valid <= 1'b1;
                end
              end
              3'd2: begin
                weight_address <= weight_ptr;
                weight_data    <= {cmp_values[1], cmp_values[0]};
                weight_enable  <= 1'b1;
                weight_write   <= 4'hF;
                weight_ptr     <= weight_ptr + 1'b1;
              end
              default: begin
                weight_address <= weight_ptr;
                weight_data    <= {cmp_values[1], cmp_values[0]};
                weight_enable  <= 1'b1;
                weight_write   <= 4'hF;
                weight_ptr     <= weight_ptr + 1'b1;
                stage_word     <= {cmp_values[3], cmp_values[2]};
                stage_valid    <= 1'b1;
              end
            endcase

            if (meta_count_next == 5'(META_PER_WORD)) begin
              metadata_address <= meta_ptr;
              metadata_data    <= meta_merged;
              metadata_enable  <= 1'b1;
              metadata_write   <= 4'hF;
              meta_ptr         <= meta_ptr + 1'b1;
              meta_acc         <= '0;
              meta_count       <= '0;
            end else begin
              meta_acc   <= meta_merged;
              meta_count <= meta_count_next;
            end
          end
        end

        default: ;
      endcase
    end
  end

`ifdef VEGETA_PACKER_STATS_EN
  // Per-job counters: accepted blocks, violating blocks, weight words written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_count    <= '0;
      viol_count   <= '0;
      weight_words <= '0;
    end else if (state == IDLE && start) begin
      blk_count    <= '0;
      viol_count   <= '0;
      weight_words <= '0;
    end else begin
      if (accept)                  blk_count    <= blk_count + 32'd1;
      if (accept && cmp_violation) viol_count   <= viol_count + 32'd1;
      if (weight_enable)           weight_words <= weight_words + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
